csr_fwd_pipe: RTL and testbench

CSR_FWD_PIPE -- requirements
Module: csr_fwd_pipe

---
 rtl/cpu_params_pkg.sv | 6 +
 rtl/cpu_structs_pkg.sv | 12 +
 rtl/csr_pipe_stage.sv | 26 ++
 rtl/csr_fwd_pipe.sv | 64 ++++++
 tb/tb_csr_fwd_pipe.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
// cpu_params_pkg: shared CPU widths (RSZ data, GPR_ASZ register address, CSR_ASZ csr address)
package cpu_params_pkg;
  localparam int RSZ = 32;
  localparam int GPR_ASZ = 5;
  localparam int CSR_ASZ = 12;
endpackage

// File: rtl/cpu_structs_pkg.sv
// cpu_structs_pkg: csr_pipe_entry_t, the payload carried by each csr pipe stage
package cpu_structs_pkg;
  import cpu_params_pkg::*;
  typedef struct packed {
    logic               csr_wr;
    logic [CSR_ASZ-1:0] csr_addr;
    logic [RSZ-1:0]     csr_wr_data;
    logic [RSZ-1:0]     nxt_csr_rd_data;
    logic [GPR_ASZ-1:0] rd_addr;
    logic [RSZ-1:0]     rd_data;
  } csr_pipe_entry_t;
endpackage

// File: rtl/csr_pipe_stage.sv
// csr_pipe_stage: valid+entry register; i_load wins over i_clr; ports clk_in, reset_in, i_load, i_clr, i_d -> o_valid, o_q
module csr_pipe_stage
  import cpu_structs_pkg::*;
(
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            i_load,
  input  logic            i_clr,
  input  csr_pipe_entry_t i_d,
  output logic            o_valid,
  output csr_pipe_entry_t o_q
);
  logic            r_valid;
  csr_pipe_entry_t r_q;
  always_ff @(posedge clk_in) begin
    if (reset_in || (i_clr && !i_load)) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end
  assign o_valid = r_valid;
  assign o_q     = r_q;
endmodule

// File: rtl/csr_fwd_pipe.sv
// csr_fwd_pipe: two-stage (M young, W old) CSR result pipe with flush and M-priority forwarding; in_* accepted into M, out_* driven from W, fwd_* answers fwd_addr
module csr_fwd_pipe
  import cpu_structs_pkg::*;
#(
  parameter int RSZ     = cpu_params_pkg::RSZ,
  parameter int GPR_ASZ = cpu_params_pkg::GPR_ASZ
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_csr_wr,
  input  logic [11:0]        in_csr_addr,
  input  logic [RSZ-1:0]     in_csr_wr_data,
  input  logic [RSZ-1:0]     in_nxt_csr_rd_data,
  input  logic [GPR_ASZ-1:0] in_rd_addr,
  input  logic [RSZ-1:0]     in_rd_data,
  input  logic               flush_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_csr_wr,
  output logic [11:0]        out_csr_addr,
  output logic [RSZ-1:0]     out_csr_wr_data,
  output logic [GPR_ASZ-1:0] out_rd_addr,
  output logic [RSZ-1:0]     out_rd_data,
  input  logic [11:0]        fwd_addr,
  output logic               fwd_hit,
  output logic [RSZ-1:0]     fwd_data,
  output logic [1:0]         pend_cnt
);
  csr_pipe_entry_t w_in, w_m, w_w;
  logic w_m_valid, w_w_valid, w_commit, w_w_load, w_w_clr, w_m_load, w_m_clr;
  logic w_m_nxt, w_w_nxt, w_m_hit, w_w_hit;
  logic [1:0] r_pend_cnt;
  assign w_in = '{csr_wr: in_csr_wr, csr_addr: in_csr_addr, csr_wr_data: in_csr_wr_data,
                  nxt_csr_rd_data: in_nxt_csr_rd_data, rd_addr: in_rd_addr, rd_data: in_rd_data};
  assign w_commit = w_w_valid && out_ready;
  // a flush kills M, so it must not advance into W in the same cycle
  assign w_w_load = w_m_valid && (!w_w_valid || w_commit) && !flush_in;
  assign w_w_clr  = w_commit || flush_in;
  assign in_ready = !reset_in && !flush_in && (!w_m_valid || w_w_load);
  assign w_m_load = in_valid && in_ready;
  assign w_m_clr  = w_w_load || flush_in;
  assign w_m_nxt  = w_m_load || (w_m_valid && !w_m_clr);
  assign w_w_nxt  = w_w_load || (w_w_valid && !w_w_clr);
  csr_pipe_stage u_m (.clk_in(clk_in), .reset_in(reset_in), .i_load(w_m_load), .i_clr(w_m_clr),
                      .i_d(w_in), .o_valid(w_m_valid), .o_q(w_m));
  csr_pipe_stage u_w (.clk_in(clk_in), .reset_in(reset_in), .i_load(w_w_load), .i_clr(w_w_clr),
                      .i_d(w_m), .o_valid(w_w_valid), .o_q(w_w));
  always_ff @(posedge clk_in) begin
    r_pend_cnt <= reset_in ? 2'd0 : {1'b0, w_m_nxt} + {1'b0, w_w_nxt};
  end
  assign pend_cnt        = r_pend_cnt;
  assign out_valid       = w_w_valid;
  assign out_csr_wr      = w_w.csr_wr;
  assign out_csr_addr    = w_w.csr_addr;
  assign out_csr_wr_data = w_w.csr_wr_data;
  assign out_rd_addr     = w_w.rd_addr;
  assign out_rd_data     = w_w.rd_data;
  assign w_m_hit  = w_m_valid && w_m.csr_wr && (w_m.csr_addr == fwd_addr);
  assign w_w_hit  = w_w_valid && w_w.csr_wr && (w_w.csr_addr == fwd_addr);
  assign fwd_hit  = w_m_hit || w_w_hit;
  assign fwd_data = w_m_hit ? w_m.nxt_csr_rd_data : w_w_hit ? w_w.nxt_csr_rd_data : '0;
endmodule

// File: tb/tb_csr_fwd_pipe.sv
// tb_csr_fwd_pipe: scoreboard bench for csr_fwd_pipe covering flow, backpressure, forwarding, flush and reset
module tb_csr_fwd_pipe;
  import cpu_structs_pkg::*;
  logic clk_in = 1'b0, reset_in = 1'b1, in_valid = 1'b0, flush_in = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_csr_wr, fwd_hit;
  logic [11:0] out_csr_addr, fwd_addr = '0;
  logic [31:0] out_csr_wr_data, out_rd_data, fwd_data;
  logic [4:0] out_rd_addr;
  logic [1:0] pend_cnt;
  csr_pipe_entry_t cur = '0, e, hold;
  csr_pipe_entry_t sb[$];
  int n_cmp = 0, n_err = 0;
  always #5 clk_in = ~clk_in;
  csr_fwd_pipe dut (
    .clk_in(clk_in), .reset_in(reset_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_csr_wr(cur.csr_wr), .in_csr_addr(cur.csr_addr), .in_csr_wr_data(cur.csr_wr_data),
    .in_nxt_csr_rd_data(cur.nxt_csr_rd_data), .in_rd_addr(cur.rd_addr), .in_rd_data(cur.rd_data),
    .flush_in(flush_in), .out_valid(out_valid), .out_ready(out_ready), .out_csr_wr(out_csr_wr),
    .out_csr_addr(out_csr_addr), .out_csr_wr_data(out_csr_wr_data), .out_rd_addr(out_rd_addr),
    .out_rd_data(out_rd_data), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pend_cnt(pend_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [31:0] nx, input logic [4:0] rd, input logic [31:0] rdd);
    in_valid = v;
    cur = '{csr_wr: wr, csr_addr: a, csr_wr_data: wd, nxt_csr_rd_data: nx, rd_addr: rd, rd_data: rdd};
  endtask
  task automatic tick();
    #1;
    if (reset_in) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_csr_wr", out_csr_wr, e.csr_wr);
          chk("sb_csr_addr", out_csr_addr, e.csr_addr);
          chk("sb_csr_wr_data", out_csr_wr_data, e.csr_wr_data);
          chk("sb_rd_addr", out_rd_addr, e.rd_addr);
          chk("sb_rd_data", out_rd_data, e.rd_data);
        end
      end
      if (flush_in) sb.delete();
      else if (in_valid && in_ready) sb.push_back(cur);
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask
  initial begin
    @(negedge clk_in);
    #1 chk("rst_in_ready", in_ready, 0);
    tick();
    tick();
    reset_in = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_out_addr", out_csr_addr, 0);
    chk("rst_in_ready_after", in_ready, 1);
    out_ready = 1'b1;
    drive(1, 1, 12'h300, 32'h8, 32'h8, 5'd1, 32'h11);
    tick();
    drive(1, 1, 12'h341, 32'h100, 32'h100, 5'd2, 32'h22);
    #1 chk("b2b_c1_valid", out_valid, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("b2b_c2_valid", out_valid, 1);
    chk("b2b_c2_addr", out_csr_addr, 12'h300);
    tick();
    chk("b2b_c3_valid", out_valid, 1);
    chk("b2b_c3_addr", out_csr_addr, 12'h341);
    tick();
    chk("b2b_idle", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 1, 12'h301, 32'h1, 32'h10, 5'd3, 32'h33);
    tick();
    drive(1, 0, 12'h302, 32'h2, 32'h20, 5'd4, 32'h44);
    tick();
    drive(1, 1, 12'h303, 32'h3, 32'h30, 5'd5, 32'h55);
    #1 chk("bp_in_ready", in_ready, 0);
    chk("bp_pend", pend_cnt, 2);
    hold = '{csr_wr: out_csr_wr, csr_addr: out_csr_addr, csr_wr_data: out_csr_wr_data,
             nxt_csr_rd_data: '0, rd_addr: out_rd_addr, rd_data: out_rd_data};
    chk("bp_head_addr", out_csr_addr, 12'h301);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stable", {out_csr_wr, out_csr_addr, out_csr_wr_data, out_rd_addr, out_rd_data},
          {hold.csr_wr, hold.csr_addr, hold.csr_wr_data, hold.rd_addr, hold.rd_data});
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_drained", sb.size(), 0);
    out_ready = 1'b0;
    drive(1, 1, 12'h305, 32'h5555, 32'h5555, 5'd6, 32'h66);
    tick();
    drive(1, 1, 12'h305, 32'hAAAA, 32'hAAAA, 5'd7, 32'h77);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    fwd_addr = 12'h305;
    #1 chk("fwd_hit_both", fwd_hit, 1);
    chk("fwd_data_m_prio", fwd_data, 32'hAAAA);
    fwd_addr = 12'h306;
    #1 chk("fwd_miss_hit", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    chk("fl_pend_pre", pend_cnt, 2);
    out_ready = 1'b1;
    flush_in = 1'b1;
    drive(1, 1, 12'h307, 32'h9, 32'h9, 5'd8, 32'h88);
    #1 chk("fl_in_ready", in_ready, 0);
    chk("fl_w_addr", out_csr_addr, 12'h305);
    tick();
    flush_in = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("fl_pend_post", pend_cnt, 0);
    chk("fl_out_valid", out_valid, 0);
    tick();
    chk("fl_dropped", out_valid, 0);
    drive(1, 0, 12'h300, 32'h1234, 32'h1234, 5'd7, 32'hDEAD);
    fwd_addr = 12'h300;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("nw_hit_m", fwd_hit, 0);
    tick();
    chk("nw_hit_w", fwd_hit, 0);
    chk("nw_valid", out_valid, 1);
    chk("nw_rd_addr", out_rd_addr, 5'd7);
    chk("nw_rd_data", out_rd_data, 32'hDEAD);
    tick();
    out_ready = 1'b0;
    drive(1, 1, 12'h340, 32'hA, 32'hA, 5'd9, 32'h99);
    tick();
    drive(1, 1, 12'h340, 32'hB, 32'hB, 5'd10, 32'hAA);
    tick();
    fwd_addr = 12'h340;
    #1 chk("rm_pend_pre", pend_cnt, 2);
    reset_in = 1'b1;
    out_ready = 1'b1;
    flush_in = 1'b1;
    tick();
    reset_in = 1'b0;
    flush_in = 1'b0;
    drive(1, 1, 12'h342, 32'hC, 32'hC, 5'd11, 32'hBB);
    #1 chk("rm_out_valid", out_valid, 0);
    chk("rm_pend", pend_cnt, 0);
    chk("rm_fwd_hit", fwd_hit, 0);
    chk("rm_fwd_data", fwd_data, 0);
    chk("rm_out_fields", {out_csr_wr, out_csr_addr, out_csr_wr_data, out_rd_addr, out_rd_data}, 0);
    chk("rm_in_ready", in_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rm_resume_valid", out_valid, 1);
    chk("rm_resume_addr", out_csr_addr, 12'h342);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)),
            $urandom, $urandom, 5'($urandom), $urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    chk("final_drain", sb.size(), 0);
    chk("final_valid", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
